// File: rtl/auth_tx_arbiter_pkg.sv
// Shared state encoding, requester indices and pointer helper for auth_tx_arbiter.
package auth_tx_arbiter_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'b0001,
    ST_SEND     = 4'b0010,
    ST_WAIT_RSP = 4'b0100,
    ST_DELIVER  = 4'b1000
  } state_e;

  localparam int REQ_DIGEST = 0;
  localparam int REQ_CERT   = 1;
  localparam int REQ_CHAL   = 2;

  // Round-robin successor of idx in a ring of n requesters.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/auth_tx_arbiter_rr_arbiter.sv
// Combinational round-robin winner: first set req bit found starting at ptr and wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any,
  output logic [NUM_REQ-1:0] win_onehot,
  output logic [IDX_W-1:0]   win_idx
);

  always_comb begin
    int idx;
    any        = 1'b0;
    win_onehot = '0;
    win_idx    = '0;
    idx        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any && req[idx]) begin
        any             = 1'b1;
        win_idx         = IDX_W'(idx);
        win_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/auth_tx_arbiter.sv
// Shares the outbound auth-message channel among requesters and routes the reply back.
// Define AUTH_TX_ARB_TIMEOUT_EN to enable the response timeout in WAIT_RSP.
`ifndef MSG_LEN
`define MSG_LEN 256
`endif

module auth_tx_arbiter
  import auth_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int MSG_W       = `MSG_LEN,
  parameter int TIMEOUT_CYC = 1024,
  parameter int TMO_W       = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*MSG_W-1:0] req_msg,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       sent_ack,
  output logic                     tx_valid,
  output logic [MSG_W-1:0]         tx_msg,
  input  logic                     tx_ack,
  input  logic                     rx_valid,
  input  logic [MSG_W-1:0]         rx_msg,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [MSG_W-1:0]         rsp_msg,
  output logic [NUM_REQ-1:0]       rsp_timeout,
  input  logic                     abort,
  output logic                     busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (TIMEOUT_CYC < 2 || (TIMEOUT_CYC >> TMO_W) != 0) begin : g_bad_cfg
    $error("auth_tx_arbiter: TIMEOUT_CYC must be >= 2 and below 2**TMO_W");
  end

  state_e               state_reg;
  state_e               state_next;
  logic [NUM_REQ-1:0]   grant_reg;
  logic [NUM_REQ-1:0]   sent_ack_reg;
  logic [MSG_W-1:0]     tx_msg_reg;
  logic [MSG_W-1:0]     rsp_msg_reg;
  logic [IDX_W-1:0]     ptr_reg;
  logic                 arb_any;
  logic [NUM_REQ-1:0]   arb_onehot;
  logic [IDX_W-1:0]     arb_idx;
  logic                 tmo_hit;
  logic [MSG_W-1:0]     req_msg_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_msg_arr[gi] = req_msg[gi*MSG_W +: MSG_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req        (req),
    .ptr        (ptr_reg),
    .any        (arb_any),
    .win_onehot (arb_onehot),
    .win_idx    (arb_idx)
  );

`ifdef AUTH_TX_ARB_TIMEOUT_EN
  logic [TMO_W-1:0]   tmo_cnt_reg;
  logic [NUM_REQ-1:0] rsp_timeout_reg;

  // A response or abort on the terminal-count cycle suppresses the timeout.
  assign tmo_hit = (state_reg == ST_WAIT_RSP) && !rx_valid && !abort &&
                   (tmo_cnt_reg == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt_reg     <= '0;
      rsp_timeout_reg <= '0;
    end else begin
      rsp_timeout_reg <= tmo_hit ? grant_reg : '0;
      if (state_reg == ST_SEND)
        tmo_cnt_reg <= '0;
      else if (state_reg == ST_WAIT_RSP && !rx_valid && !abort)
        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end
  end

  assign rsp_timeout = rsp_timeout_reg;
`else
  assign tmo_hit     = 1'b0;
  assign rsp_timeout = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:     if (arb_any) state_next = ST_SEND;
        ST_SEND:     if (tx_ack) state_next = ST_WAIT_RSP;
        ST_WAIT_RSP: begin
          if (rx_valid)     state_next = ST_DELIVER;
          else if (tmo_hit) state_next = ST_IDLE;
        end
        ST_DELIVER:  state_next = ST_IDLE;
        default:     state_next = ST_IDLE;
      endcase
    end
  end

  // Ownership, message latches and the round-robin pointer; abort leaves the pointer alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_reg    <= '0;
      sent_ack_reg <= '0;
      tx_msg_reg   <= '0;
      rsp_msg_reg  <= '0;
      ptr_reg      <= '0;
    end else begin
      sent_ack_reg <= '0;
      if (abort) begin
        grant_reg <= '0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (arb_any) begin
              grant_reg  <= arb_onehot;
              tx_msg_reg <= req_msg_arr[arb_idx];
              ptr_reg    <= IDX_W'(rr_next(int'(arb_idx), NUM_REQ));
            end
          end
          ST_SEND: begin
            if (tx_ack) sent_ack_reg <= grant_reg;
          end
          ST_WAIT_RSP: begin
            if (rx_valid)     rsp_msg_reg <= rx_msg;
            else if (tmo_hit) grant_reg   <= '0;
          end
          default: grant_reg <= '0;
        endcase
      end
    end
  end

  always_comb begin
    grant     = grant_reg;
    sent_ack  = sent_ack_reg;
    tx_valid  = (state_reg == ST_SEND);
    tx_msg    = tx_msg_reg;
    rsp_msg   = rsp_msg_reg;
    rsp_valid = (state_reg == ST_DELIVER) ? grant_reg : '0;
    busy      = (state_reg != ST_IDLE);
  end

endmodule

// File: tb/tb_auth_tx_arbiter.sv
// Directed + randomized bench for auth_tx_arbiter against a transaction-level model.
module tb_auth_tx_arbiter;
  import auth_tx_arbiter_pkg::*;

  localparam int N    = 3;
  localparam int MW   = 64;
  localparam int TCYC = 8;
  localparam logic [MW-1:0] ZERO = '0;
  localparam logic [MW-1:0] ONE  = 1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*MW-1:0] req_msg = '0;
  logic [N-1:0]    grant, sent_ack, rsp_valid, rsp_timeout;
  logic            tx_valid, busy;
  logic [MW-1:0]   tx_msg, rsp_msg;
  logic            tx_ack = 1'b0;
  logic            rx_valid = 1'b0;
  logic [MW-1:0]   rx_msg = '0;
  logic            abort = 1'b0;

  int checks = 0;
  int errors = 0;
  int m_ptr = 0;
  logic [MW-1:0] m_rsp = '0;
  logic [MW-1:0] msgs [N];

  auth_tx_arbiter #(
    .NUM_REQ(N), .MSG_W(MW), .TIMEOUT_CYC(TCYC), .TMO_W(4)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_msg(req_msg),
    .grant(grant), .sent_ack(sent_ack), .tx_valid(tx_valid), .tx_msg(tx_msg),
    .tx_ack(tx_ack), .rx_valid(rx_valid), .rx_msg(rx_msg),
    .rsp_valid(rsp_valid), .rsp_msg(rsp_msg), .rsp_timeout(rsp_timeout),
    .abort(abort), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    chk("grant_onehot", MW'($onehot0(grant)), ONE);
    chk("one_pulse", MW'($countones({|sent_ack, |rsp_valid, |rsp_timeout}) <= 1), ONE);
  endtask

  // Round-robin rule: first requester at or after the pointer, wrapping.
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic set_msgs();
    for (int i = 0; i < N; i++) begin
      msgs[i] = {$urandom, $urandom};
      req_msg[i*MW +: MW] = msgs[i];
    end
  endtask

  task automatic run_txn(input logic [N-1:0] rq, input int ack_dly, input int rsp_dly,
                         input bit give_rsp, input bit drop_req, output int w);
    logic [N-1:0]  oh;
    logic [MW-1:0] rmsg;
    set_msgs();
    req   = rq;
    w     = pick(rq, m_ptr);
    m_ptr = (w + 1) % N;
    oh    = N'(1) << w;
    rmsg  = {$urandom, $urandom};
    step();
    chk("tx_valid", MW'(tx_valid), ONE);
    chk("grant", MW'(grant), MW'(oh));
    chk("tx_msg", tx_msg, msgs[w]);
    chk("busy", MW'(busy), ONE);
    chk("stale_pulses", MW'({sent_ack, rsp_valid, rsp_timeout}), ZERO);
    if (drop_req) req = '0;
    rx_valid = 1'b1;
    rx_msg   = {$urandom, $urandom};
    for (int i = 0; i < ack_dly; i++) begin
      step();
      chk("tx_hold", tx_msg, msgs[w]);
      chk("tx_valid_hold", MW'(tx_valid), ONE);
      chk("sent_ack_early", MW'(sent_ack), ZERO);
    end
    tx_ack = 1'b1;
    step();
    tx_ack   = 1'b0;
    rx_valid = 1'b0;
    chk("sent_ack", MW'(sent_ack), MW'(oh));
    chk("tx_valid_drop", MW'(tx_valid), ZERO);
    chk("rsp_msg_keep", rsp_msg, m_rsp);
    if (give_rsp) begin
      for (int i = 1; i < rsp_dly; i++) begin
        step();
        chk("sent_ack_len", MW'(sent_ack), ZERO);
        chk("rsp_early", MW'(rsp_valid), ZERO);
        chk("tmo_early", MW'(rsp_timeout), ZERO);
      end
      rx_valid = 1'b1;
      rx_msg   = rmsg;
      step();
      rx_valid = 1'b0;
      m_rsp    = rmsg;
      chk("rsp_valid", MW'(rsp_valid), MW'(oh));
      chk("rsp_msg", rsp_msg, rmsg);
      chk("rsp_no_tmo", MW'(rsp_timeout), ZERO);
      step();
      chk("grant_clear", MW'(grant), ZERO);
      chk("idle_after_rsp", MW'(busy), ZERO);
    end else begin
`ifdef AUTH_TX_ARB_TIMEOUT_EN
      for (int i = 1; i < TCYC; i++) begin
        step();
        chk("tmo_early", MW'(rsp_timeout), ZERO);
        chk("tmo_busy", MW'(busy), ONE);
      end
      step();
      chk("rsp_timeout", MW'(rsp_timeout), MW'(oh));
      chk("tmo_grant_clear", MW'(grant), ZERO);
      chk("tmo_idle", MW'(busy), ZERO);
      chk("tmo_no_rsp", MW'(rsp_valid), ZERO);
`else
      for (int i = 0; i < 3 * TCYC; i++) begin
        step();
        chk("wait_busy", MW'(busy), ONE);
        chk("no_tmo_pulse", MW'(rsp_timeout), ZERO);
      end
      rx_valid = 1'b1;
      rx_msg   = rmsg;
      step();
      rx_valid = 1'b0;
      m_rsp    = rmsg;
      chk("late_rsp_valid", MW'(rsp_valid), MW'(oh));
      step();
      chk("idle_after_late_rsp", MW'(busy), ZERO);
`endif
    end
    $display("txn req=%b winner=%0d ack_dly=%0d rsp_dly=%0d rsp=%0d drop=%0d", rq, w, ack_dly, rsp_dly, give_rsp, drop_req);
  endtask

  initial begin
    int w;
    int exp_order [4];
    exp_order = '{REQ_DIGEST, REQ_CERT, REQ_CHAL, REQ_DIGEST};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", MW'(grant), ZERO);
    chk("rst_tx_valid", MW'(tx_valid), ZERO);
    chk("rst_busy", MW'(busy), ZERO);
    chk("rst_tx_msg", tx_msg, ZERO);
    chk("rst_rsp_msg", rsp_msg, ZERO);
    chk("rst_pulses", MW'({sent_ack, rsp_valid, rsp_timeout}), ZERO);
    reset = 1'b0;

    // contention with all requesters held from pointer 0
    for (int i = 0; i < 4; i++) begin
      run_txn(3'b111, 1, 2, 1'b1, 1'b0, w);
      chk("rr_order", MW'(w), MW'(exp_order[i]));
    end

    run_txn(3'b010, 2, 5, 1'b1, 1'b0, w);
    run_txn(3'b001, 0, 0, 1'b0, 1'b0, w);
    run_txn(3'b100, 2, TCYC, 1'b1, 1'b0, w);
    run_txn(3'b110, 1, 3, 1'b1, 1'b1, w);
    run_txn(3'b011, 0, 1, 1'b1, 1'b0, w);

    // abort in WAIT_RSP together with a response, then a late response
    set_msgs();
    req   = 3'b111;
    w     = pick(req, m_ptr);
    m_ptr = (w + 1) % N;
    step();
    chk("abort_grant", MW'(grant), MW'(N'(1) << w));
    tx_ack = 1'b1;
    step();
    tx_ack = 1'b0;
    step();
    abort    = 1'b1;
    rx_valid = 1'b1;
    rx_msg   = {$urandom, $urandom};
    step();
    abort = 1'b0;
    req   = '0;
    chk("abort_busy", MW'(busy), ZERO);
    chk("abort_grant_clear", MW'(grant), ZERO);
    chk("abort_no_pulse", MW'({sent_ack, rsp_valid, rsp_timeout}), ZERO);
    chk("abort_rsp_msg", rsp_msg, m_rsp);
    step();
    rx_valid = 1'b0;
    chk("late_rx_busy", MW'(busy), ZERO);
    chk("late_rx_rsp_valid", MW'(rsp_valid), ZERO);
    chk("late_rx_rsp_msg", rsp_msg, m_rsp);
    $display("txn abort in WAIT_RSP owner=%0d", w);
    run_txn(3'b111, 0, 2, 1'b1, 1'b0, w);

    // abort in SEND beats tx_ack
    set_msgs();
    req   = 3'b101;
    w     = pick(req, m_ptr);
    m_ptr = (w + 1) % N;
    step();
    chk("abort_send_tx_valid", MW'(tx_valid), ONE);
    tx_ack = 1'b1;
    abort  = 1'b1;
    step();
    tx_ack = 1'b0;
    abort  = 1'b0;
    req    = '0;
    chk("abort_send_no_ack", MW'(sent_ack), ZERO);
    chk("abort_send_tx_drop", MW'(tx_valid), ZERO);
    chk("abort_send_busy", MW'(busy), ZERO);
    $display("txn abort in SEND owner=%0d", w);

    for (int i = 0; i < 16; i++)
      run_txn(N'($urandom_range(1, 7)), $urandom_range(0, 3), $urandom_range(1, TCYC),
              $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), w);

    // async reset between edges while in SEND
    set_msgs();
    req = 3'b011;
    step();
    chk("pre_reset_tx_valid", MW'(tx_valid), ONE);
    #2 reset = 1'b1;
    #1;
    chk("areset_tx_valid", MW'(tx_valid), ZERO);
    chk("areset_grant", MW'(grant), ZERO);
    chk("areset_busy", MW'(busy), ZERO);
    chk("areset_tx_msg", tx_msg, ZERO);
    req = '0;
    step();
    reset = 1'b0;
    m_ptr = 0;
    m_rsp = '0;
    chk("areset_rsp_msg", rsp_msg, ZERO);
    rx_valid = 1'b1;
    rx_msg   = {$urandom, $urandom};
    step();
    rx_valid = 1'b0;
    chk("idle_rx_dropped", rsp_msg, ZERO);
    chk("idle_rx_no_pulse", MW'(rsp_valid), ZERO);
    $display("txn async reset mid-SEND");
    run_txn(3'b111, 1, 2, 1'b1, 1'b0, w);
    chk("post_reset_winner", MW'(w), MW'(REQ_DIGEST));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
